// File: rtl/vfpu_unpack_if.sv
// Operand stream into the VFPU unpack stage and the unpacked result stream out of it.
// master = producer/consumer side, slave = unpack stage.
interface vfpu_unpack_if #(
   parameter int unsigned FP_EXP_WIDTH         = 8,
   parameter int unsigned FP_MANT_WIDTH        = 23,
   parameter int unsigned FP_EXP_PRENORM_WIDTH = 10
);
   logic                                    in_valid_i;
   logic                                    in_ready_o;
   logic [FP_EXP_WIDTH+FP_MANT_WIDTH:0]     operand_i;
   logic                                    out_valid_o;
   logic                                    out_ready_i;
   logic                                    sign_o;
   logic [FP_EXP_PRENORM_WIDTH-1:0]         exponent_o;
   logic [FP_MANT_WIDTH:0]                  mantissa_o;
   logic                                    is_zero_o;
   logic                                    is_denormal_o;
   logic                                    is_inf_o;
   logic                                    is_nan_o;
   logic                                    is_snan_o;

   modport master (
      output in_valid_i, operand_i, out_ready_i,
      input  in_ready_o, out_valid_o, sign_o, exponent_o, mantissa_o,
             is_zero_o, is_denormal_o, is_inf_o, is_nan_o, is_snan_o
   );

   modport slave (
      input  in_valid_i, operand_i, out_ready_i,
      output in_ready_o, out_valid_o, sign_o, exponent_o, mantissa_o,
             is_zero_o, is_denormal_o, is_inf_o, is_nan_o, is_snan_o
   );
endinterface

// File: rtl/vfpu_unpack.sv
// VFPU operand unpack / pre-normalization: two-stage elastic pipeline that splits packed
// single-precision words, classifies them and left-normalizes denormals.
module vfpu_unpack #(
   parameter int unsigned FP_EXP_WIDTH         = 8,
   parameter int unsigned FP_MANT_WIDTH        = 23,
   parameter int unsigned FP_EXP_PRENORM_WIDTH = 10
) (
   input logic          clk_i,
   input logic          rst_i,
   input logic          clear_i,
   vfpu_unpack_if.slave bus
);
   localparam int unsigned EW  = FP_EXP_WIDTH;
   localparam int unsigned MW  = FP_MANT_WIDTH;
   localparam int unsigned PW  = FP_EXP_PRENORM_WIDTH;
   localparam int unsigned LZW = $clog2(MW);

   if (PW < EW + 2) begin : g_bad_width
      $error("FP_EXP_PRENORM_WIDTH must be >= FP_EXP_WIDTH+2");
   end

   typedef struct packed {
      logic           sign;
      logic [EW-1:0]  exp;
      logic [MW-1:0]  frac;
      logic [LZW-1:0] lz;
      logic           is_zero;
      logic           is_denormal;
      logic           is_inf;
      logic           is_nan;
      logic           is_snan;
   } s1_t;

   typedef struct packed {
      logic          sign;
      logic [PW-1:0] exp;
      logic [MW:0]   mant;
      logic          is_zero;
      logic          is_denormal;
      logic          is_inf;
      logic          is_nan;
      logic          is_snan;
   } s2_t;

   logic [2:1] vld_pipe;
   s1_t        s1_d, s1_q;
   s2_t        s2_d, s2_q;
   logic       in_ready, push, s2_load;

   // Last write wins, so the result is the distance from the highest set bit to the MSB.
   function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] f);
      lzc = '0;
      for (int i = 0; i < int'(MW); i++)
         if (f[i]) lzc = LZW'(int'(MW) - 1 - i);
   endfunction

   always_comb begin
      logic exp_zero, exp_ones, frac_zero;
      s1_d      = '0;
      s1_d.sign = bus.operand_i[EW+MW];
      s1_d.exp  = bus.operand_i[EW+MW-1:MW];
      s1_d.frac = bus.operand_i[MW-1:0];
      s1_d.lz   = lzc(s1_d.frac);
      exp_zero  = (s1_d.exp == '0);
      exp_ones  = &s1_d.exp;
      frac_zero = (s1_d.frac == '0);
      s1_d.is_zero     = exp_zero & frac_zero;
      s1_d.is_denormal = exp_zero & ~frac_zero;
      s1_d.is_inf      = exp_ones & frac_zero;
      s1_d.is_nan      = exp_ones & ~frac_zero;
      s1_d.is_snan     = exp_ones & ~frac_zero & ~s1_d.frac[MW-1];
   end

   // Normal, inf and NaN all pass {1, frac} with the raw exponent; only zero/denormal differ.
   always_comb begin
      s2_d             = '0;
      s2_d.sign        = s1_q.sign;
      s2_d.exp         = PW'(s1_q.exp);
      s2_d.mant        = {1'b1, s1_q.frac};
      s2_d.is_zero     = s1_q.is_zero;
      s2_d.is_denormal = s1_q.is_denormal;
      s2_d.is_inf      = s1_q.is_inf;
      s2_d.is_nan      = s1_q.is_nan;
      s2_d.is_snan     = s1_q.is_snan;
      if (s1_q.is_zero) begin
         s2_d.exp  = '0;
         s2_d.mant = '0;
      end else if (s1_q.is_denormal) begin
         s2_d.exp  = PW'(0) - PW'(s1_q.lz);
         s2_d.mant = {1'b0, s1_q.frac} << (s1_q.lz + LZW'(1));
      end
   end

   // Clear drops any offered operand, so advertising ready during it is harmless.
   assign in_ready = ~rst_i & (clear_i | ~vld_pipe[1] | ~vld_pipe[2] | bus.out_ready_i);
   assign push     = bus.in_valid_i & in_ready & ~clear_i;
   assign s2_load  = vld_pipe[1] & (~vld_pipe[2] | bus.out_ready_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
      end else begin
         if (clear_i) begin
            vld_pipe <= '0;
         end else begin
            if (push)                 vld_pipe[1] <= 1'b1;
            else if (s2_load)         vld_pipe[1] <= 1'b0;
            if (s2_load)              vld_pipe[2] <= 1'b1;
            else if (bus.out_ready_i) vld_pipe[2] <= 1'b0;
         end
         if (push)    s1_q <= s1_d;
         if (s2_load) s2_q <= s2_d;
      end
   end

   assign bus.in_ready_o    = in_ready;
   assign bus.out_valid_o   = vld_pipe[2];
   assign bus.sign_o        = s2_q.sign;
   assign bus.exponent_o    = s2_q.exp;
   assign bus.mantissa_o    = s2_q.mant;
   assign bus.is_zero_o     = s2_q.is_zero;
   assign bus.is_denormal_o = s2_q.is_denormal;
   assign bus.is_inf_o      = s2_q.is_inf;
   assign bus.is_nan_o      = s2_q.is_nan;
   assign bus.is_snan_o     = s2_q.is_snan;
endmodule

// File: tb/tb_vfpu_unpack.sv
// Bench for vfpu_unpack: value model + scoreboard checked every output cycle,
// plus directed literal vectors, backpressure and flush scenarios.
module tb_vfpu_unpack;
   logic clk = 1'b0;
   logic rst, clear;
   int   errors = 0;
   int   checks = 0;

   vfpu_unpack_if bus ();

   vfpu_unpack dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clear),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Result word: {sign, exp[9:0], mant[23:0], zero, denorm, inf, nan, snan}
   function automatic logic [39:0] model(input logic [31:0] w);
      logic        s;
      int          e, x;
      logic [23:0] m;
      s = w[31];
      e = int'(w[30:23]);
      m = {1'b0, w[22:0]};
      if (e == 0 && m == 0) return {s, 10'd0, 24'd0, 5'b10000};
      if (e == 0) begin
         x = 0;
         while (m < 24'h800000) begin
            m = m * 2;
            x = x - 1;
         end
         return {s, 10'(x + 1), m, 5'b01000};
      end
      if (e == 255 && m == 0) return {s, 10'd255, 24'h800000, 5'b00100};
      if (e == 255) return {s, 10'd255, 24'h800000 + m, 3'b000, 1'b1, (m < 24'h400000)};
      return {s, 10'(e), 24'h800000 + m, 5'b00000};
   endfunction

   function automatic logic [39:0] dut_vec();
      return {bus.sign_o, bus.exponent_o, bus.mantissa_o, bus.is_zero_o, bus.is_denormal_o,
              bus.is_inf_o, bus.is_nan_o, bus.is_snan_o};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
   endtask

   // Scoreboard / protocol monitor, sampled mid-cycle
   logic [39:0] q[$];
   logic [39:0] prev_out;
   logic        hold_prev = 1'b0;
   logic        prev_flush = 1'b0;

   always @(negedge clk) begin
      if (prev_flush) chk("flush_valid", 64'(bus.out_valid_o), 64'd0);
      if (rst) chk("rst_ready", 64'(bus.in_ready_o), 64'd0);
      if (clear && !rst) chk("clear_ready", 64'(bus.in_ready_o), 64'd1);
      if (hold_prev) begin
         chk("hold_valid", 64'(bus.out_valid_o), 64'd1);
         chk("hold_data", 64'(dut_vec()), 64'(prev_out));
      end
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i && !rst && !clear) begin
         if (q.size() == 0) chk("unexpected_out", 64'(dut_vec()), 64'hx);
         else chk("scoreboard", 64'(dut_vec()), 64'(q.pop_front()));
      end
      if (rst || clear) q.delete();
      else if (bus.in_valid_i && bus.in_ready_o === 1'b1) q.push_back(model(bus.operand_i));
      hold_prev  = (bus.out_valid_o === 1'b1) && !bus.out_ready_i && !rst && !clear;
      prev_out   = dut_vec();
      prev_flush = rst || clear;
   end

   // Single operand on an empty pipe: visible two edges after it is presented
   task automatic directed(input string nm, input logic [31:0] w, input logic [39:0] exp_v);
      chk({"model_", nm}, 64'(model(w)), 64'(exp_v));
      @(posedge clk); #1;
      bus.in_valid_i  = 1'b1;
      bus.operand_i   = w;
      bus.out_ready_i = 1'b1;
      #1 chk({"ready_", nm}, 64'(bus.in_ready_o), 64'd1);
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      chk({"lat1_", nm}, 64'(bus.out_valid_o), 64'd0);
      @(posedge clk); #1;
      chk({"lat2_", nm}, 64'(bus.out_valid_o), 64'd1);
      chk({"val_", nm}, 64'(dut_vec()), 64'(exp_v));
   endtask

   logic [31:0] vec [10];
   int          i;
   logic        acc;

   initial begin
      vec = '{32'h3F800000, 32'h00000001, 32'h00400000, 32'h80000000, 32'hFF800000,
              32'h7F800001, 32'h7FC00000, 32'h807FFFFF, 32'h7F7FFFFF, 32'h00000003};
      rst = 1'b1;
      clear = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.operand_i   = '0;
      bus.out_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("reset_outputs", 64'({bus.out_valid_o, dut_vec()}), 64'd0);
      chk("reset_ready", 64'(bus.in_ready_o), 64'd1);

      directed("one",      32'h3F800000, {1'b0, 10'd127,   24'h800000, 5'b00000});
      directed("dmin",     32'h00000001, {1'b0, 10'h3EA,   24'h800000, 5'b01000});
      directed("dtop",     32'h00400000, {1'b0, 10'd0,     24'h800000, 5'b01000});
      directed("nzero",    32'h80000000, {1'b1, 10'd0,     24'h000000, 5'b10000});
      directed("ninf",     32'hFF800000, {1'b1, 10'd255,   24'h800000, 5'b00100});
      directed("snan",     32'h7F800001, {1'b0, 10'd255,   24'h800001, 5'b00011});
      directed("qnan",     32'h7FC00000, {1'b0, 10'd255,   24'hC00000, 5'b00010});
      directed("dmax",     32'h807FFFFF, {1'b1, 10'd0,     24'hFFFFFE, 5'b01000});
      directed("maxnorm",  32'h7F7FFFFF, {1'b0, 10'd254,   24'hFFFFFF, 5'b00000});
      directed("d3",       32'h00000003, {1'b0, 10'h3EB,   24'hC00000, 5'b01000});

      // Stream 8 operands with the consumer stalled for the first 5 cycles
      @(posedge clk); #1;
      i = 0;
      for (int c = 0; c < 60 && i < 8; c++) begin
         bus.in_valid_i  = 1'b1;
         bus.operand_i   = vec[i];
         bus.out_ready_i = (c >= 5);
         #1;
         acc = bus.in_ready_o;
         chk("stream_ready", 64'(acc), 64'((c < 2) || (c >= 5)));
         if (acc) i++;
         @(posedge clk); #1;
      end
      bus.in_valid_i = 1'b0;
      chk("stream_count", 64'(i), 64'd8);
      repeat (4) @(posedge clk);

      // clear with two in flight plus a same-cycle offered operand
      #1 bus.out_ready_i = 1'b0;
      bus.in_valid_i = 1'b1;
      bus.operand_i  = vec[0];
      @(posedge clk); #1 bus.operand_i = vec[1];
      @(posedge clk); #1;
      clear = 1'b1;
      bus.operand_i = vec[2];
      @(posedge clk); #1;
      clear = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      repeat (6) @(posedge clk);
      #1 directed("post_clear", 32'h3F800000, {1'b0, 10'd127, 24'h800000, 5'b00000});

      // reset with two in flight
      @(posedge clk); #1;
      bus.out_ready_i = 1'b0;
      bus.in_valid_i  = 1'b1;
      bus.operand_i   = vec[4];
      @(posedge clk); #1 bus.operand_i = vec[5];
      @(posedge clk); #1;
      rst = 1'b1;
      bus.in_valid_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.out_ready_i = 1'b1;
      #1 chk("post_rst_ready", 64'(bus.in_ready_o), 64'd1);
      chk("post_rst_outputs", 64'({bus.out_valid_o, dut_vec()}), 64'd0);
      repeat (6) @(posedge clk);
      #1 directed("post_rst", 32'h00000001, {1'b0, 10'h3EA, 24'h800000, 5'b01000});

      for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
      @(negedge clk);
      chk("drain", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
